uart_tx_stim: RTL and testbench
===============================

Name: uart_tx_stim

Overview:
- Testbench-side UART transmitter that serializes bytes onto the DUT `uart_rx_i` pin.
- It is the counterpart of the UART monitor, which receives from `uart_tx_o`.
- It buffers bytes pushed by bench code in a small FIFO and frames each one as start, 8 data bits LSB-first, optional parity and stop.
- Bit timing comes from the DUT baud tick (`tick_baud_x16`), so sender and receiver always share one baud setting.
- The block can inject framing and parity errors to exercise the DUT receiver's error paths.

Parameters:
- FIFO_DEPTH, 8, number of byte entries in the transmit FIFO; must be a power of 2 and at least 2.
- CNT_W, 16, width of the `frames_sent` counter.

Ports:
- core_clk  input  1  clock.
- rst_l  input  1  reset, asynchronous, active-low.
- tx_enable  input  1  enables the start of new frames.
- tick_baud_x16  input  1  single-cycle pulse at 16x the baud rate.
- parity_enable  input  1  adds a parity bit after the data bits.
- parity_odd  input  1  1 selects odd parity, 0 selects even parity.
- inject_frame_err  input  1  when sampled at frame start, the stop bit is driven 0.
- inject_parity_err  input  1  when sampled at frame start, the parity bit is inverted.
- push_valid  input  1  byte present on `push_data`.
- push_data  input  8  byte to transmit.
- push_ready  output  1  FIFO can accept a byte.
- tx  output  1  serial line, idle high.
- busy  output  1  a frame is in progress.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  number of bytes in the FIFO.
- frames_sent  output  CNT_W  count of completed frames; wraps.

Behaviour:
- Reset (asynchronous on `rst_l` low) values:
  - `tx`=1, `busy`=0, `fifo_level`=0, `frames_sent`=0, FIFO pointers=0, state=IDLE.
  - `push_ready`=1, since it is combinational from level.
  - Reset mid-frame aborts the frame immediately: `tx` returns to 1 and FIFO contents are discarded.
- FIFO:
  - `push_ready` = (`fifo_level` < FIFO_DEPTH).
  - A push is accepted when `push_valid` and `push_ready` are both high. A push while full is ignored, with no error.
  - A pop occurs in the cycle IDLE transitions to START.
  - Simultaneous push and pop: level unchanged, both operations take effect.
  - A push while full is rejected even if a pop occurs in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- Bit timing:
  - A 4-bit subtick counter increments on each `tick_baud_x16` pulse.
  - A bit ends on the 16th tick, when the counter wraps from 15 to 0.
  - One bit = 16 ticks. Ticks are ignored in IDLE; the counter is held at 0 there.
- State machine (IDLE, START, DATA, PARITY, STOP):
  - IDLE: `tx`=1, `busy`=0. If `tx_enable` and `fifo_level`>0, then on the next clock:
    - pop the byte into the shift register;
    - latch `parity_enable`, `parity_odd`, `inject_frame_err` and `inject_parity_err`;
    - clear the subtick counter and go to START.
  - START: `tx`=0 for 16 ticks, then go to DATA with bit index 0.
  - DATA: `tx` = shift[index] for 16 ticks each, indices 0..7.
    - After index 7: go to PARITY if the latched parity enable is set, else to STOP.
  - PARITY: `tx` = ^data XOR latched_odd XOR latched_parity_err, held for 16 ticks, then go to STOP.
  - STOP: `tx` = ~latched_frame_err for 16 ticks. At completion, `frames_sent` increments and the state returns to IDLE.
  - `busy`=1 in every state except IDLE.
- `tx` is registered; state changes and `tx` changes happen on the same clock edge.
- Back-to-back frames:
  - IDLE lasts exactly 1 core_clk cycle between frames when the FIFO is non-empty.
  - No extra idle bits are inserted.
- `tx_enable` deasserted mid-frame: the current frame completes and no new frame starts.
- Configuration inputs changing mid-frame have no effect until the next frame starts.
- `frames_sent` wraps from 2^CNT_W−1 to 0.

Test Plan:
- Basic frame: push 0x55 with parity off and `tick_baud_x16` every 4 clocks.
  - `tx` = 0, 1,0,1,0,1,0,1,0, 1, with each bit lasting 64 clocks.
  - `frames_sent`=1 and `busy` returns to 0.
- Parity: push 0x07 with even parity, then 0x07 with odd parity.
  - Parity bit = 1 for the even case and 0 for the odd case.
  - The DUT receiver reports both bytes with no `rx_parity_err`.
- Error injection:
  - Push 0xA3 with `inject_parity_err`=1 and even parity → DUT reports a parity error.
  - Push 0xA3 with `inject_frame_err`=1 → stop bit reads 0 and the DUT reports a frame error.
- FIFO full / back-to-back:
  - Hold `tx_enable`=0 and push 9 bytes 0x30..0x38 → `push_ready` goes 0 after 8 pushes, 0x38 is dropped, and `fifo_level`=8.
  - Then set `tx_enable`=1 → 8 contiguous frames 0x30..0x37 with 1-cycle idle gaps, `frames_sent`=8.
- Enable/reset mid-frame:
  - Drop `tx_enable` during DATA of the 1st of 2 queued frames → only the 1st frame completes, `fifo_level`=1.
  - Assert `rst_l`=0 mid-frame → `tx`=1 asynchronously, and `fifo_level`=0, `frames_sent`=0.

Source files
------------

// File: rtl/uart_tx_stim.sv
// uart_tx_stim: bench-side UART transmitter driving a DUT receive pin.
// Buffers pushed bytes in a FIFO and frames them at the DUT baud tick.
//
// Ports:
//   core_clk, rst_l      clock, async active-low reset
//   tx_enable            allow new frames to start
//   tick_baud_x16        one-cycle pulse at 16x baud
//   parity_enable        append parity bit
//   parity_odd           1 = odd parity, 0 = even
//   inject_frame_err     drive stop bit low (latched per frame)
//   inject_parity_err    invert parity bit (latched per frame)
//   push_valid/data      byte push into FIFO
//   push_ready           FIFO not full
//   tx                   serial line, idle high
//   busy                 frame in progress
//   fifo_level           bytes held in FIFO
//   frames_sent          completed frames, wrapping
module uart_tx_stim #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                        core_clk,
  input  logic                        rst_l,
  input  logic                        tx_enable,
  input  logic                        tick_baud_x16,
  input  logic                        parity_enable,
  input  logic                        parity_odd,
  input  logic                        inject_frame_err,
  input  logic                        inject_parity_err,
  input  logic                        push_valid,
  input  logic [7:0]                  push_data,
  output logic                        push_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]            frames_sent
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       sub_q, sub_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             pen_q, pen_d;
  logic             podd_q, podd_d;
  logic             ferr_q, ferr_d;
  logic             perr_q, perr_d;
  logic             tx_q, tx_d;
  logic [CNT_W-1:0] frames_q, frames_d;
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [LW-1:0]    lvl_q, lvl_d;

  logic [7:0]       mem [FIFO_DEPTH];

  logic             do_push;
  logic             do_pop;
  logic             bit_end;

  // Fullness uses the current level only, so a push while full
  // is dropped even if a pop happens in the same cycle.
  assign push_ready = (lvl_q < FULL);
  assign do_push    = push_valid && push_ready;
  assign do_pop     = (state_q == S_IDLE) && tx_enable
                      && (lvl_q != '0);

  // A bit ends on the 16th tick, i.e. the 15 -> 0 wrap.
  assign bit_end    = tick_baud_x16 && (sub_q == 4'hF)
                      && (state_q != S_IDLE);

  assign tx          = tx_q;
  assign busy        = (state_q != S_IDLE);
  assign fifo_level  = lvl_q;
  assign frames_sent = frames_q;

  // FIFO storage needs no reset; pointers define validity.
  always_ff @(posedge core_clk) begin
    if (do_push) begin
      mem[wptr_q] <= push_data;
    end
  end

  always_ff @(posedge core_clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q  <= S_IDLE;
      sub_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      pen_q    <= 1'b0;
      podd_q   <= 1'b0;
      ferr_q   <= 1'b0;
      perr_q   <= 1'b0;
      tx_q     <= 1'b1;
      frames_q <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      lvl_q    <= '0;
    end else begin
      state_q  <= state_d;
      sub_q    <= sub_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      pen_q    <= pen_d;
      podd_q   <= podd_d;
      ferr_q   <= ferr_d;
      perr_q   <= perr_d;
      tx_q     <= tx_d;
      frames_q <= frames_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      lvl_q    <= lvl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (do_pop) state_d = S_START;
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end && (idx_q == 3'd7)) begin
          state_d = pen_q ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sub_d    = sub_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    pen_d    = pen_q;
    podd_d   = podd_q;
    ferr_d   = ferr_q;
    perr_d   = perr_q;
    frames_d = frames_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    lvl_d    = lvl_q;

    // Subtick is parked at 0 while idle, so a frame
    // always starts on a fresh bit period.
    if (state_q == S_IDLE) begin
      sub_d = '0;
    end else if (tick_baud_x16) begin
      sub_d = sub_q + 4'd1;
    end

    if (bit_end && (state_q == S_START)) begin
      idx_d = '0;
    end else if (bit_end && (state_q == S_DATA)) begin
      idx_d = idx_q + 3'd1;
    end

    // Configuration is frozen per frame at the pop.
    if (do_pop) begin
      shift_d = mem[rptr_q];
      pen_d   = parity_enable;
      podd_d  = parity_odd;
      ferr_d  = inject_frame_err;
      perr_d  = inject_parity_err;
      rptr_d  = rptr_q + PW'(1);
    end

    if (do_push) begin
      wptr_d = wptr_q + PW'(1);
    end

    unique case (1'b1)
      (do_push && !do_pop): lvl_d = lvl_q + LW'(1);
      (do_pop && !do_push): lvl_d = lvl_q - LW'(1);
      default:              lvl_d = lvl_q;
    endcase

    if (bit_end && (state_q == S_STOP)) begin
      frames_d = frames_q + CNT_W'(1);
    end
  end

  // tx is driven from next-state values so the line and
  // the state register change on the same edge.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[idx_d];
      S_PARITY: tx_d = (^shift_d) ^ podd_d ^ perr_d;
      S_STOP:   tx_d = ~ferr_d;
      default:  tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_stim.sv
// tb_uart_tx_stim: random and directed checks of uart_tx_stim.
// A line decoder plus byte queue model predicts every frame.
module tb_uart_tx_stim;

  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic          core_clk   = 1'b0;
  logic          rst_l      = 1'b0;
  logic          tx_enable  = 1'b0;
  logic          tick       = 1'b0;
  logic          par_en     = 1'b0;
  logic          par_odd    = 1'b0;
  logic          ferr       = 1'b0;
  logic          perr       = 1'b0;
  logic          push_valid = 1'b0;
  logic [7:0]    push_data  = 8'h00;
  logic          push_ready;
  logic          tx;
  logic          busy;
  logic [3:0]    fifo_level;
  logic [CW-1:0] frames_sent;

  uart_tx_stim #(
    .FIFO_DEPTH(DEPTH),
    .CNT_W     (CW)
  ) u_dut (
    .core_clk         (core_clk),
    .rst_l            (rst_l),
    .tx_enable        (tx_enable),
    .tick_baud_x16    (tick),
    .parity_enable    (par_en),
    .parity_odd       (par_odd),
    .inject_frame_err (ferr),
    .inject_parity_err(perr),
    .push_valid       (push_valid),
    .push_data        (push_data),
    .push_ready       (push_ready),
    .tx               (tx),
    .busy             (busy),
    .fifo_level       (fifo_level),
    .frames_sent      (frames_sent)
  );

  always #5 core_clk = ~core_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Baud tick generator, period in clocks set by stimulus.
  int tick_gap = 4;
  int tick_ctr = 0;
  always @(posedge core_clk) begin
    #1;
    if (tick_ctr >= tick_gap - 1) begin
      tick     = 1'b1;
      tick_ctr = 0;
    end else begin
      tick     = 1'b0;
      tick_ctr = tick_ctr + 1;
    end
  end

  // Reference model: byte queue, frame counter, line decoder.
  logic [7:0]  q_model [$];
  int          frames_m  = 0;
  logic        in_frame  = 1'b0;
  int          tcnt      = 0;
  int          nbits     = 10;
  logic [10:0] bits_v;
  logic        cur_bit;
  logic        stable;
  logic [7:0]  f_data;
  logic        f_pen, f_odd, f_ferr, f_perr;
  logic        c_pen, c_odd, c_ferr, c_perr;
  logic        prev_tx   = 1'b1;
  logic        end_pend  = 1'b0;
  logic        exp_start = 1'b0;
  logic        exp_b2b   = 1'b0;
  logic [7:0]  last_data;
  logic        last_par;
  logic        last_stop;

  always @(negedge core_clk) begin
    if (!rst_l) begin
      q_model.delete();
      frames_m  = 0;
      in_frame  = 1'b0;
      tcnt      = 0;
      end_pend  = 1'b0;
      exp_start = 1'b0;
      prev_tx   = 1'b1;
    end else begin
      if (exp_start) begin
        exp_start = 1'b0;
        if (exp_b2b) check("b2b_start", tx, 0);
        else         check("idle_hold", tx, 1);
      end
      if (end_pend) begin
        end_pend = 1'b0;
        check("end_busy", busy, 0);
        check("end_tx", tx, 1);
        check("frames", frames_sent, frames_m);
        exp_start = 1'b1;
        exp_b2b   = (q_model.size() > 0) && tx_enable;
      end
      if (!in_frame && prev_tx && !tx) begin
        if (q_model.size() == 0) begin
          check("spurious_start", 1, 0);
          f_data = 8'h00;
        end else begin
          f_data = q_model.pop_front();
        end
        f_pen    = c_pen;
        f_odd    = c_odd;
        f_ferr   = c_ferr;
        f_perr   = c_perr;
        nbits    = f_pen ? 11 : 10;
        in_frame = 1'b1;
        tcnt     = 0;
        stable   = 1'b1;
        bits_v   = '0;
        check("level_at_start", fifo_level, q_model.size());
      end
      if (in_frame) begin
        if (tick) begin
          tcnt = tcnt + 1;
          if ((tcnt - 1) % 16 == 0) cur_bit = tx;
        end
        if (tcnt > 0 && (tick || (tcnt % 16) != 0)) begin
          if (tx !== cur_bit) stable = 1'b0;
        end
        if (tick && (tcnt % 16) == 0) begin
          bits_v[tcnt/16 - 1] = cur_bit;
        end
        if (tick && tcnt == 16 * nbits) begin
          check("start_bit", bits_v[0], 0);
          check("data", bits_v[8:1], f_data);
          if (f_pen) begin
            check("parity", bits_v[9],
                  ($countones(f_data) % 2) ^ f_odd ^ f_perr);
          end
          check("stop", bits_v[nbits-1], !f_ferr);
          check("bit_stable", stable, 1);
          last_data = bits_v[8:1];
          last_par  = bits_v[9];
          last_stop = bits_v[nbits-1];
          frames_m  = (frames_m + 1) % (1 << CW);
          in_frame  = 1'b0;
          end_pend  = 1'b1;
        end
      end
      if (push_valid) begin
        check("push_ready", push_ready, q_model.size() < DEPTH);
        check("level", fifo_level, q_model.size());
        if (q_model.size() < DEPTH) q_model.push_back(push_data);
      end
      c_pen   = par_en;
      c_odd   = par_odd;
      c_ferr  = ferr;
      c_perr  = perr;
      prev_tx = tx;
    end
  end

  task automatic step();
    @(posedge core_clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    push_valid = 1'b1;
    push_data  = b;
    step();
    push_valid = 1'b0;
  endtask

  task automatic set_cfg(input logic pe, input logic po,
                         input logic fe, input logic qe);
    par_en  = pe;
    par_odd = po;
    ferr    = fe;
    perr    = qe;
  endtask

  task automatic wait_idle(input int limit);
    for (int n = 0; n < limit; n++) begin
      step();
      if (q_model.size() == 0 && !in_frame && !busy
          && !end_pend && !exp_start) return;
    end
    check("timeout_idle", 0, 1);
  endtask

  task automatic wait_mid(input int min_ticks);
    int n;
    n = 0;
    while (!(in_frame && tcnt >= min_ticks) && n < 5000) begin
      step();
      n++;
    end
    check("wait_mid", in_frame && tcnt >= min_ticks, 1);
  endtask

  initial begin
    step();
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_level", fifo_level, 0);
    check("rst_frames", frames_sent, 0);
    check("rst_ready", push_ready, 1);
    rst_l = 1'b1;
    step();

    set_cfg(0, 0, 0, 0);
    tx_enable = 1'b1;
    push_byte(8'h55);
    wait_idle(3000);
    check("basic_data", last_data, 8'h55);
    check("basic_frames", frames_sent, 1);

    set_cfg(1, 0, 0, 0);
    push_byte(8'h07);
    wait_idle(3000);
    check("par_even", last_par, 1);
    set_cfg(1, 1, 0, 0);
    push_byte(8'h07);
    wait_idle(3000);
    check("par_odd", last_par, 0);

    set_cfg(1, 0, 0, 1);
    push_byte(8'hA3);
    wait_idle(3000);
    check("perr_par", last_par, 1);
    set_cfg(0, 0, 1, 0);
    push_byte(8'hA3);
    wait_idle(3000);
    check("ferr_stop", last_stop, 0);
    check("err_frames", frames_sent, 5);

    set_cfg(0, 0, 0, 0);
    tx_enable = 1'b0;
    step();
    for (int i = 0; i < 9; i++) begin
      push_valid = 1'b1;
      push_data  = 8'h30 + 8'(i);
      step();
    end
    push_valid = 1'b0;
    step();
    check("full_ready", push_ready, 0);
    check("full_level", fifo_level, 8);
    tx_enable = 1'b1;
    wait_idle(20000);
    check("full_frames", frames_sent, 13);

    tx_enable = 1'b0;
    push_byte(8'h11);
    push_byte(8'h22);
    tx_enable = 1'b1;
    wait_mid(40);
    tx_enable = 1'b0;
    for (int n = 0; n < 5000 && (in_frame || busy); n++) step();
    repeat (200) step();
    check("drop_level", fifo_level, 1);
    check("drop_busy", busy, 0);
    check("drop_frames", frames_sent, 14);
    tx_enable = 1'b1;
    wait_idle(3000);
    check("drain_frames", frames_sent, 15);

    for (int i = 0; i < 30; i++) begin
      int w;
      tick_gap = $urandom_range(1, 3);
      set_cfg($urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 1), $urandom_range(0, 1));
      push_byte(8'($urandom_range(0, 255)));
      w = $urandom_range(0, 600);
      repeat (w / 2) step();
      set_cfg($urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 1), $urandom_range(0, 1));
      repeat (w - w / 2) step();
    end
    wait_idle(40000);
    check("rand_frames", frames_sent, frames_m);

    tick_gap = 4;
    set_cfg(0, 0, 0, 0);
    push_byte(8'h5A);
    push_byte(8'hC3);
    wait_mid(0);
    #2;
    check("pre_rst_tx", tx, 0);
    rst_l = 1'b0;
    #1;
    check("arst_tx", tx, 1);
    check("arst_busy", busy, 0);
    check("arst_level", fifo_level, 0);
    check("arst_frames", frames_sent, 0);
    repeat (3) step();
    rst_l = 1'b1;
    repeat (400) step();
    check("post_rst_tx", tx, 1);
    check("post_rst_level", fifo_level, 0);
    check("post_rst_frames", frames_sent, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
